// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter.
//   arb_state_e   : arbiter FSM state (no owner / one owner holds the grant)
//   ARB_MAX_N     : widest one-hot vector onehot_to_idx accepts
//   onehot_to_idx : index of the set bit of a one-hot (or zero) vector
package arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_e;

    localparam int ARB_MAX_N = 64;

    // An all-zero vector maps to index 0. Callers zero-extend narrower vectors
    // to ARB_MAX_N bits and truncate the result to their own index width.
    function automatic int unsigned onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) idx |= unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
//   req  [N]    : request vector
//   ptr  [IDXW] : index where the search starts; priority falls off upward and wraps
//   pick [N]    : one-hot winner, zero when req is zero
// The lower copy of req is masked below ptr, so the first set bit of the
// doubled vector is the first requester at or after ptr, wrapping once.
module rr_pick #(
    parameter  int N    = 4,
    localparam int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [N-1:0]    pick
);

    logic [N-1:0]   hi_mask;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] first;
    logic           found;

    always_comb begin
        // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latch).
        hi_mask = '0;
        first   = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            hi_mask[i] = (i >= int'(ptr));
        end
        dbl = {req, req & hi_mask};
        for (int i = 0; i < 2 * N; i++) begin
            if (!found && dbl[i]) begin
                first[i] = 1'b1;
                found    = 1'b1;
            end
        end
        pick = first[N-1:0] | first[2*N-1:N];
    end

endmodule

// File: rtl/rr_arbiter_param.sv
// N-way round-robin arbiter with a registered one-hot grant and hold quantum.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   en         : arbitration enable; low clears the grant
//   req  [N]   : request per requester
//   lock [N]   : owner extends its grant past HOLD_MAX (only while it requests)
//   gnt  [N]   : registered grant, one-hot or zero
//   gnt_valid  : any grant active
//   gnt_idx    : index of the current owner, 0 when no grant
// An owner keeps the grant for up to HOLD_MAX cycles (unbounded under lock);
// on release the next requester after it wins in the same cycle.
module rr_arbiter_param
    import arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int HOLD_MAX = 4,
    localparam int IDXW     = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    lock,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [IDXW-1:0] gnt_idx
);

    localparam int CW = $clog2(HOLD_MAX + 1);

    if (N < 2) begin : g_bad_n
        $error("rr_arbiter_param: N must be at least 2");
    end
    if (N > ARB_MAX_N) begin : g_big_n
        $error("rr_arbiter_param: N exceeds ARB_MAX_N");
    end
    if (HOLD_MAX < 1) begin : g_bad_hold
        $error("rr_arbiter_param: HOLD_MAX must be at least 1");
    end

    arb_state_e      state, state_n;
    logic [N-1:0]    gnt_n;
    logic [IDXW-1:0] last, last_n;
    logic [CW-1:0]   hold_cnt, hold_n;

    logic [IDXW-1:0] base;
    logic [IDXW-1:0] ptr;
    logic [N-1:0]    pick;
    logic            keep;

    assign gnt_valid = |gnt;
    assign gnt_idx   = IDXW'(onehot_to_idx(ARB_MAX_N'(gnt)));

    // Search starts one past the owner, or one past the last winner when idle.
    assign base = (state == ARB_OWNED) ? gnt_idx : last;
    assign ptr  = (base == IDXW'(N - 1)) ? '0 : base + 1'b1;

    rr_pick #(.N(N)) u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick)
    );

    assign keep = (state == ARB_OWNED) && req[gnt_idx] &&
                  (lock[gnt_idx] || (hold_cnt < CW'(HOLD_MAX)));

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        last_n  = last;
        hold_n  = hold_cnt;
        if (!en) begin
            state_n = ARB_IDLE;
            gnt_n   = '0;
            hold_n  = '0;
        end else if (keep) begin
            // Saturates under lock so the counter never wraps.
            hold_n = (hold_cnt == CW'(HOLD_MAX)) ? hold_cnt : hold_cnt + 1'b1;
        end else if (|req) begin
            // The owner itself may win again when it is the only requester.
            state_n = ARB_OWNED;
            gnt_n   = pick;
            last_n  = IDXW'(onehot_to_idx(ARB_MAX_N'(pick)));
            hold_n  = CW'(1);
        end else begin
            state_n = ARB_IDLE;
            gnt_n   = '0;
            hold_n  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            gnt      <= '0;
            last     <= IDXW'(N - 1);
            hold_cnt <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all of them update from the same pre-edge values.
            state    <= state_n;
            gnt      <= gnt_n;
            last     <= last_n;
            hold_cnt <= hold_n;
        end
    end

endmodule
